// File: rtl/seg_bus_pkg.sv
// rtl/seg_bus_pkg.sv - segment pattern and nibble constants for the display bus decoder
package seg_bus_pkg;

    // Active-high segment patterns, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_9_ALT = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_LO    = 7'h5C;

    // Nibbles reported for the two non-numeric glyphs
    localparam logic [3:0] NIB_BLANK = 4'hA;
    localparam logic [3:0] NIB_LO    = 4'hF;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational 7-segment pattern to nibble decoder
module seg_pattern_decode
    import seg_bus_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       known,
    output logic       blank,
    output logic [3:0] nibble
);

    // Map each recognised glyph to its code; anything else is flagged unknown
    always_comb begin
        known  = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_9_ALT: nibble = 4'h9;
            SEG_BLANK: begin
                nibble = NIB_BLANK;
                blank  = 1'b1;
            end
            SEG_LO:    nibble = NIB_LO;
            default:   known  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_bus_decoder.sv
// rtl/seg_bus_decoder.sv - multiplexed 7-segment bus receiver and frame assembler
module seg_bus_decoder
    import seg_bus_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic [4*NUM_DIGITS-1:0] value_bcd,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    value_valid,
    output logic                    code_err
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]           sync1;
    logic [SW-1:0]           sync2;
    logic [SW-1:0]           samp;
    logic [SW-1:0]           prev_samp;
    logic [CW-1:0]           cnt;
    logic [NUM_DIGITS-1:0]   strobe;
    logic [6:0]              segs;
    logic                    one_hot;
    logic                    stable;
    logic                    capture;
    logic                    dec_known;
    logic                    dec_blank;
    logic [3:0]              dec_nibble;
    logic [4*NUM_DIGITS-1:0] shadow_nib;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   mask;
    logic                    frame_done;
    logic [NUM_DIGITS-1:0]   mask_base;

    // Two-stage synchroniser on the raw (active-low) bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {dig_sel_n, seg_n};
            sync2 <= sync1;
        end
    end

    assign samp    = ~sync2;
    assign strobe  = samp[SW-1:7];
    assign segs    = samp[6:0];
    assign one_hot = $onehot(strobe);
    assign stable  = one_hot && (samp == prev_samp);
    // Capture exactly once, on the step into saturation
    assign capture = stable && (cnt == CNT_PRE);

    // Stability counter: runs while the one-hot sample repeats, saturates at the threshold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_samp <= '0;
            cnt       <= '0;
        end else begin
            prev_samp <= samp;
            if (!stable) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    seg_pattern_decode u_decode (
        .pattern (segs),
        .known   (dec_known),
        .blank   (dec_blank),
        .nibble  (dec_nibble)
    );

    assign frame_done = &mask;
    // A completed frame hands off this cycle, so a simultaneous capture starts from empty
    assign mask_base  = frame_done ? '0 : mask;

    // Shadow/mask assembly and publication of completed frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_nib   <= '0;
            shadow_blank <= '0;
            mask         <= '0;
            value_bcd    <= '0;
            blank_mask   <= '0;
            value_valid  <= 1'b0;
            code_err     <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            code_err    <= 1'b0;
            mask        <= mask_base;
            if (frame_done) begin
                value_bcd   <= shadow_nib;
                blank_mask  <= shadow_blank;
                value_valid <= 1'b1;
            end
            if (capture) begin
                if (dec_known) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (strobe[i]) begin
                            shadow_nib[4*i +: 4] <= dec_nibble;
                            shadow_blank[i]      <= dec_blank;
                        end
                    end
                    mask <= mask_base | strobe;
                end else begin
                    code_err     <= 1'b1;
                    mask         <= '0;
                    shadow_nib   <= '0;
                    shadow_blank <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_bus_decoder.sv
// tb/tb_seg_bus_decoder.sv - self-checking bench for seg_bus_decoder
module tb_seg_bus_decoder;

    localparam int N = 4;
    localparam int S = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [6:0]     seg_n = 7'h7F;
    logic [N-1:0]   dig_sel_n = '1;
    logic [4*N-1:0] value_bcd;
    logic [N-1:0]   blank_mask;
    logic           value_valid;
    logic           code_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seg_bus_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_sel_n   (dig_sel_n),
        .value_bcd   (value_bcd),
        .blank_mask  (blank_mask),
        .value_valid (value_valid),
        .code_err    (code_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events
    logic [4*N+N-1:0] obs_q[$];
    int obs_err = 0;
    int last_vv_cyc = -1;

    always @(negedge clk) begin
        if (!reset) begin
            if (value_valid) begin
                obs_q.push_back({value_bcd, blank_mask});
                last_vv_cyc = cyc;
            end
            if (code_err) obs_err++;
        end
    end

    // Reference model: a digit is captured once per distinct, long-enough one-hot step
    logic [4*N+N-1:0] exp_q[$];
    int exp_err = 0;
    bit       seen[N];
    logic [3:0] ref_nib[N];
    bit       ref_blank[N];
    logic [N+6:0] prev_pins = '0;

    function automatic void ref_decode(input logic [6:0] p, output bit known,
                                       output bit blank, output logic [3:0] nib);
        known = 1; blank = 0; nib = 0;
        case (p)
            7'h3F: nib = 0;  7'h06: nib = 1;  7'h5B: nib = 2;  7'h4F: nib = 3;
            7'h66: nib = 4;  7'h6D: nib = 5;  7'h7D: nib = 6;  7'h07: nib = 7;
            7'h7F: nib = 8;  7'h67: nib = 9;  7'h6F: nib = 9;
            7'h00: begin nib = 4'hA; blank = 1; end
            7'h5C: nib = 4'hF;
            default: known = 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) seen[i] = 0;
    endtask

    task automatic model_apply(input int d, input logic [6:0] p);
        bit k, b;
        logic [3:0] nb;
        bit all;
        logic [4*N-1:0] w;
        logic [N-1:0] m;
        ref_decode(p, k, b, nb);
        if (!k) begin
            exp_err++;
            model_clear();
            return;
        end
        seen[d] = 1; ref_nib[d] = nb; ref_blank[d] = b;
        all = 1;
        for (int i = 0; i < N; i++) if (!seen[i]) all = 0;
        if (all) begin
            for (int i = 0; i < N; i++) begin
                w[4*i +: 4] = ref_nib[i];
                m[i] = ref_blank[i];
            end
            exp_q.push_back({w, m});
            model_clear();
        end
    endtask

    task automatic drive_step(input logic [N-1:0] strobe, input logic [6:0] pat, input int hold);
        seg_n     = ~pat;
        dig_sel_n = ~strobe;
        if ($onehot(strobe) && hold >= S + 1 && {strobe, pat} != prev_pins) begin
            for (int i = 0; i < N; i++) if (strobe[i]) model_apply(i, pat);
        end
        prev_pins = {strobe, pat};
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive_step('0, 7'h00, n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Settle, then compare everything observed against the model and start afresh
    task automatic check_events(input string tag);
        int n;
        idle(25);
        chk({tag, "_frames"}, obs_q.size(), exp_q.size());
        chk({tag, "_errs"}, obs_err, exp_err);
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_word"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
        obs_err = 0;
        exp_err = 0;
    endtask

    logic [6:0] pat_tab[16];
    int p_last;

    initial begin
        pat_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h67, 7'h6F, 7'h00, 7'h5C, 7'h49, 7'h01, 7'h7E};
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(value_bcd), 32'h0);
        chk("rst_blank", 32'(blank_mask), 32'h0);
        chk("rst_vv", 32'(value_valid), 32'h0);
        chk("rst_err", 32'(code_err), 32'h0);
        reset = 1'b0;
        idle(5);

        // Basic frame with latency check on the last digit
        drive_step(4'b0001, 7'h3F, 20);
        drive_step(4'b0010, 7'h06, 20);
        drive_step(4'b0100, 7'h5B, 20);
        p_last = cyc;
        drive_step(4'b1000, 7'h4F, 20);
        idle(10);
        chk("lat_vv", 32'(last_vv_cyc), 32'(p_last + S + 4));
        chk("frame_bcd", 32'(value_bcd), 32'h3210);
        chk("frame_blank", 32'(blank_mask), 32'h0);
        check_events("frame");

        // Blank, 'o' and both nines
        drive_step(4'b0001, 7'h00, 20);
        drive_step(4'b0010, 7'h5C, 20);
        drive_step(4'b0100, 7'h67, 20);
        drive_step(4'b1000, 7'h6F, 20);
        idle(10);
        chk("glyph_bcd", 32'(value_bcd), 32'h99FA);
        chk("glyph_blank", 32'(blank_mask), 32'h1);
        check_events("glyph");

        // Re-holding the last digit must not recapture it
        drive_step(4'b0001, 7'h06, 20);
        drive_step(4'b0010, 7'h06, 20);
        drive_step(4'b0100, 7'h06, 20);
        drive_step(4'b1000, 7'h06, 80);
        drive_step(4'b0001, 7'h07, 20);
        drive_step(4'b0010, 7'h07, 20);
        drive_step(4'b0100, 7'h07, 20);
        check_events("rehold_a");
        drive_step(4'b1000, 7'h07, 20);
        check_events("rehold_b");

        // Glitch and multi-hot: neither captures nor errors
        drive_step(4'b0001, 7'h66, 20);
        drive_step(4'b0010, 7'h66, S - 1);
        drive_step(4'b0100, 7'h66, 20);
        drive_step(4'b1000, 7'h66, 20);
        drive_step(4'b0011, 7'h49, 40);
        drive_step(4'b1100, 7'h66, 40);
        check_events("glitch_a");
        drive_step(4'b0010, 7'h6D, 20);
        check_events("glitch_b");

        // Undecodable pattern aborts the frame, a clean frame follows
        drive_step(4'b0001, 7'h7D, 20);
        drive_step(4'b0010, 7'h7D, 20);
        drive_step(4'b0100, 7'h49, 20);
        drive_step(4'b0001, 7'h3F, 20);
        drive_step(4'b0010, 7'h7F, 20);
        drive_step(4'b0100, 7'h07, 20);
        drive_step(4'b1000, 7'h66, 20);
        check_events("error");

        // Reset mid-frame discards partial captures
        drive_step(4'b0001, 7'h4F, 20);
        drive_step(4'b0010, 7'h5B, 20);
        idle(3);
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        chk("mid_rst_bcd", 32'(value_bcd), 32'h0);
        chk("mid_rst_blank", 32'(blank_mask), 32'h0);
        chk("mid_rst_vv", 32'(value_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_step(4'b0100, 7'h6D, 20);
        drive_step(4'b1000, 7'h7D, 20);
        check_events("post_rst_a");
        drive_step(4'b0001, 7'h06, 20);
        drive_step(4'b0010, 7'h3F, 20);
        check_events("post_rst_b");

        // Randomised steps against the model
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 20; k++) begin
                logic [N-1:0] st;
                logic [6:0] pt;
                do begin
                    st = N'(1) << $urandom_range(0, N - 1);
                    pt = pat_tab[$urandom_range(0, 15)];
                end while ({st, pt} == prev_pins);
                drive_step(st, pt, int'($urandom_range(18, 25)));
            end
            check_events("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
